// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshake timeout.
// Define MC_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_controller #(
   parameter int unsigned WAIT_LIMIT = 15
`ifdef MC_PERF_CNT_EN
   ,
   parameter int unsigned PERF_W = 32
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       imem_ack,
   input  logic       dmem_ack,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       ir_write,
   output logic       pc_write,
   output logic [2:0] nPC_sel,
   output logic [1:0] RegDst,
   output logic       ALU_Asrc,
   output logic       ALU_Bsrc,
   output logic [1:0] ExtOp,
   output logic [2:0] ALUctrl,
   output logic       Mem2Reg,
   output logic       LinkPC,
   output logic       reg_write,
   output logic       mem_write,
   output logic [2:0] state,
   output logic       instr_done,
   output logic       bus_err
`ifdef MC_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] cycle_cnt,
   output logic [PERF_W-1:0] instr_cnt
`endif
);

   localparam int unsigned CntW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpAddiu = 6'h09;
   localparam logic [5:0] OpOri   = 6'h0d;
   localparam logic [5:0] OpLui   = 6'h0f;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2b;
   localparam logic [5:0] FnSll   = 6'h00;
   localparam logic [5:0] FnJr    = 6'h08;
   localparam logic [5:0] FnJalr  = 6'h09;
   localparam logic [5:0] FnAddu  = 6'h21;
   localparam logic [5:0] FnSubu  = 6'h23;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   wait_q, wait_d;

   logic rtype, is_addu, is_subu, is_sll, is_jr, is_jalr;
   logic is_j, is_jal, is_beq, is_addiu, is_ori, is_lui, is_lw, is_sw;
   logic is_imm, is_alu_r, at_limit;

   always_comb begin
      rtype    = (op == OpRtype);
      is_addu  = rtype && (func == FnAddu);
      is_subu  = rtype && (func == FnSubu);
      is_sll   = rtype && (func == FnSll);
      is_jr    = rtype && (func == FnJr);
      is_jalr  = rtype && (func == FnJalr);
      is_j     = (op == OpJ);
      is_jal   = (op == OpJal);
      is_beq   = (op == OpBeq);
      is_addiu = (op == OpAddiu);
      is_ori   = (op == OpOri);
      is_lui   = (op == OpLui);
      is_lw    = (op == OpLw);
      is_sw    = (op == OpSw);
      is_imm   = is_addiu | is_ori | is_lui;
      is_alu_r = is_addu | is_subu | is_sll;
      at_limit = (WAIT_LIMIT != 0) && (wait_q == CntW'(WAIT_LIMIT - 1));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFetch;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = '0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      nPC_sel    = 3'b000;
      RegDst     = 2'b00;
      ALU_Asrc   = 1'b0;
      ALU_Bsrc   = 1'b0;
      ExtOp      = 2'b00;
      ALUctrl    = 3'b000;
      Mem2Reg    = 1'b0;
      LinkPC     = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
      bus_err    = 1'b0;

      unique case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (at_limit) begin
               bus_err = 1'b1;
            end else begin
               wait_d = wait_q + CntW'(1);
            end
         end
         StDecode: begin
            if (is_j || is_jal) begin
               pc_write = 1'b1;
               nPC_sel  = 3'b001;
            end
            if (is_jr || is_jalr) begin
               pc_write = 1'b1;
               nPC_sel  = 3'b010;
            end
            if (is_jal) begin
               reg_write = 1'b1;
               RegDst    = 2'b10;
               LinkPC    = 1'b1;
            end
            if (is_jalr) begin
               reg_write = 1'b1;
               RegDst    = 2'b01;
               LinkPC    = 1'b1;
            end
            if (is_alu_r || is_imm || is_lw || is_sw || is_beq) begin
               state_d = StExec;
            end else begin
               instr_done = 1'b1;
               state_d    = StFetch;
            end
         end
         StExec: begin
            if (is_beq) begin
               pc_write   = zero;
               nPC_sel    = 3'b011;
               instr_done = 1'b1;
               state_d    = StFetch;
            end else if (is_lw || is_sw) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            dmem_req  = 1'b1;
            mem_write = is_sw;
            if (dmem_ack) begin
               instr_done = is_sw;
               state_d    = is_sw ? StFetch : StWb;
            end else if (at_limit) begin
               bus_err = 1'b1;
               state_d = StFetch;
            end else begin
               wait_d = wait_q + CntW'(1);
            end
         end
         StWb: begin
            reg_write  = 1'b1;
            RegDst     = rtype ? 2'b01 : 2'b00;
            Mem2Reg    = is_lw;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         default: state_d = StFetch;
      endcase

      // ALU fields stay valid from EXEC through WB since IR is stable
      if (state_q == StExec || state_q == StMem || state_q == StWb) begin
         ALU_Asrc = is_sll;
         ALU_Bsrc = is_imm | is_lw | is_sw;
         ExtOp    = is_lui ? 2'b10 : (is_addiu | is_lw | is_sw | is_beq) ? 2'b01 : 2'b00;
         ALUctrl  = is_sll ? 3'b011 : (is_ori | is_lui) ? 3'b010 :
                    (is_subu | is_beq) ? 3'b001 : 3'b000;
      end

      if (!reset_n) begin
         imem_req   = 1'b0;
         dmem_req   = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         reg_write  = 1'b0;
         mem_write  = 1'b0;
         instr_done = 1'b0;
         bus_err    = 1'b0;
      end
   end

   assign state = state_q;

`ifdef MC_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + PERF_W'(1);
         if (instr_done) instr_cnt <= instr_cnt + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: a per-instruction trace model builds the expected
// cycle-by-cycle outputs, which are compared against the DUT on the falling edge.
module tb_mc_controller;
   localparam int unsigned Limit = 15;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op, func;
   logic       zero, imem_ack, dmem_ack;
   logic       imem_req, dmem_req, ir_write, pc_write, ALU_Asrc, ALU_Bsrc;
   logic       Mem2Reg, LinkPC, reg_write, mem_write, instr_done, bus_err;
   logic [2:0] nPC_sel, ALUctrl, state;
   logic [1:0] RegDst, ExtOp;

   mc_controller #(.WAIT_LIMIT(Limit)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .func(func), .zero(zero),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
      .ir_write(ir_write), .pc_write(pc_write), .nPC_sel(nPC_sel), .RegDst(RegDst),
      .ALU_Asrc(ALU_Asrc), .ALU_Bsrc(ALU_Bsrc), .ExtOp(ExtOp), .ALUctrl(ALUctrl),
      .Mem2Reg(Mem2Reg), .LinkPC(LinkPC), .reg_write(reg_write), .mem_write(mem_write),
      .state(state), .instr_done(instr_done), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       ireq, dreq, irw, pcw;
      logic [2:0] npc;
      logic [1:0] rdst;
      logic       asrc, bsrc;
      logic [1:0] ext;
      logic [2:0] alu;
      logic       m2r, link, rw, mw, done, berr;
   } out_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] func;
      logic       ia, da, z;
      out_t       e;
   } cyc_t;

   typedef enum int {KAddu, KSubu, KSll, KJr, KJalr, KOri, KAddiu, KLui, KLw, KSw, KBeq,
                     KJ, KJal, KNop} kind_e;

   cyc_t plan[$];
   out_t obs;
   int   checks = 0, errors = 0, instr_no = 0;

   assign obs = {state, imem_req, dmem_req, ir_write, pc_write, nPC_sel, RegDst, ALU_Asrc,
                 ALU_Bsrc, ExtOp, ALUctrl, Mem2Reg, LinkPC, reg_write, mem_write, instr_done,
                 bus_err};

   task automatic check(input string tag, input logic [24:0] got, input logic [24:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic kind_e kind_of(logic [5:0] o, logic [5:0] f);
      if (o == 6'h00) begin
         case (f)
            6'h21: return KAddu;
            6'h23: return KSubu;
            6'h00: return KSll;
            6'h08: return KJr;
            6'h09: return KJalr;
            default: return KNop;
         endcase
      end
      case (o)
         6'h02: return KJ;
         6'h03: return KJal;
         6'h04: return KBeq;
         6'h09: return KAddiu;
         6'h0d: return KOri;
         6'h0f: return KLui;
         6'h23: return KLw;
         6'h2b: return KSw;
         default: return KNop;
      endcase
   endfunction

   // Expected ALU/extender fields for the EXEC..WB part of an instruction.
   function automatic out_t with_alu(logic [2:0] st, kind_e k);
      out_t e = '0;
      e.st = st;
      case (k)
         KSubu:           e.alu = 3'b001;
         KSll:            begin e.asrc = 1'b1; e.alu = 3'b011; end
         KOri:            begin e.bsrc = 1'b1; e.alu = 3'b010; end
         KAddiu, KLw, KSw: begin e.bsrc = 1'b1; e.ext = 2'b01; end
         KLui:            begin e.bsrc = 1'b1; e.ext = 2'b10; e.alu = 3'b010; end
         KBeq:            begin e.ext = 2'b01; e.alu = 3'b001; end
         default:         ;
      endcase
      return e;
   endfunction

   task automatic push(input logic [5:0] o, input logic [5:0] f, input logic ia,
                       input logic da, input logic z, input out_t e);
      cyc_t c;
      c.op = o; c.func = f; c.ia = ia; c.da = da; c.z = z; c.e = e;
      plan.push_back(c);
   endtask

   // idly/ddly: unacked cycles before the ack; >= Limit means the ack never comes.
   task automatic build(input logic [5:0] o, input logic [5:0] f, input int idly,
                        input int ddly, input logic z);
      kind_e k = kind_of(o, f);
      out_t  e;
      for (int c = 0; ; c++) begin
         e = '0;
         e.ireq = 1'b1;
         if (c == idly) begin
            e.irw = 1'b1; e.pcw = 1'b1;
            push(6'($urandom), 6'($urandom), 1'b1, rb(), rb(), e);
            break;
         end
         if (c == Limit - 1) begin
            e.berr = 1'b1;
            push(6'($urandom), 6'($urandom), 1'b0, rb(), rb(), e);
            return;
         end
         push(6'($urandom), 6'($urandom), 1'b0, rb(), rb(), e);
      end
      e = '0;
      e.st = 3'd1;
      case (k)
         KJ:    begin e.pcw = 1; e.npc = 3'b001; e.done = 1; end
         KJal:  begin e.pcw = 1; e.npc = 3'b001; e.rw = 1; e.rdst = 2'b10; e.link = 1;
                      e.done = 1; end
         KJr:   begin e.pcw = 1; e.npc = 3'b010; e.done = 1; end
         KJalr: begin e.pcw = 1; e.npc = 3'b010; e.rw = 1; e.rdst = 2'b01; e.link = 1;
                      e.done = 1; end
         KNop:  e.done = 1;
         default: ;
      endcase
      push(o, f, rb(), rb(), rb(), e);
      if (e.done) return;
      e = with_alu(3'd2, k);
      if (k == KBeq) begin
         e.pcw = z; e.npc = 3'b011; e.done = 1'b1;
         push(o, f, rb(), rb(), z, e);
         return;
      end
      push(o, f, rb(), rb(), rb(), e);
      if (k == KLw || k == KSw) begin
         for (int c = 0; ; c++) begin
            e = with_alu(3'd3, k);
            e.dreq = 1'b1;
            e.mw   = (k == KSw);
            if (c == ddly) begin
               e.done = (k == KSw);
               push(o, f, rb(), 1'b1, rb(), e);
               if (k == KSw) return;
               break;
            end
            if (c == Limit - 1) begin
               e.berr = 1'b1;
               push(o, f, rb(), 1'b0, rb(), e);
               return;
            end
            push(o, f, rb(), 1'b0, rb(), e);
         end
      end
      e = with_alu(3'd4, k);
      e.rw   = 1'b1;
      e.rdst = (o == 6'h00) ? 2'b01 : 2'b00;
      e.m2r  = (k == KLw);
      e.done = 1'b1;
      push(o, f, rb(), rb(), rb(), e);
   endtask

   // Entered and left at posedge+1; n < 0 plays the whole plan.
   task automatic play(input int n);
      int cnt = 0;
      while (plan.size() > 0 && (n < 0 || cnt < n)) begin
         cyc_t c = plan.pop_front();
         op = c.op; func = c.func; imem_ack = c.ia; dmem_ack = c.da; zero = c.z;
         @(negedge clk);
         check($sformatf("i%0d_st%0d", instr_no, c.e.st), obs, c.e);
         @(posedge clk);
         #1;
         cnt++;
      end
   endtask

   task automatic run(input logic [5:0] o, input logic [5:0] f, input int idly,
                      input int ddly, input logic z);
      build(o, f, idly, ddly, z);
      play(-1);
      instr_no++;
   endtask

   logic [11:0] itab [16];
   out_t        e;

   initial begin
      itab = '{{6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h00}, {6'h00, 6'h08},
               {6'h00, 6'h09}, {6'h0d, 6'h00}, {6'h09, 6'h00}, {6'h0f, 6'h00},
               {6'h23, 6'h00}, {6'h2b, 6'h00}, {6'h04, 6'h00}, {6'h02, 6'h00},
               {6'h03, 6'h00}, {6'h3f, 6'h00}, {6'h08, 6'h00}, {6'h05, 6'h00}};
      op = '0; func = '0; zero = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #11 check("reset", obs, '0);
      #4 reset_n = 1'b1;   // just after the posedge at t=15

      run(6'h00, 6'h21, 2, 0, 1'b0);     // addu, imem ack after 2 waits
      run(6'h23, 6'h00, 0, 3, 1'b0);     // lw, dmem ack after 3 waits
      run(6'h04, 6'h00, 0, 0, 1'b1);     // beq taken
      run(6'h04, 6'h00, 0, 0, 1'b0);     // beq not taken
      run(6'h03, 6'h00, 0, 0, 1'b0);     // jal
      run(6'h2b, 6'h00, 0, 1000, 1'b0);  // sw, dmem never acks
      run(6'h00, 6'h21, 1000, 0, 1'b0);  // fetch timeout
      run(6'h00, 6'h09, 14, 0, 1'b0);    // jalr, ack on the limit cycle
      run(6'h2b, 6'h00, 0, 14, 1'b0);    // sw, ack on the limit cycle

      for (int i = 0; i < 150; i++) begin
         logic [11:0] ent = itab[$urandom_range(0, 15)];
         logic [5:0]  f   = (ent[11:6] == 6'h00) ? ent[5:0] : 6'($urandom);
         int          id  = ($urandom_range(0, 15) == 0) ? 1000 : int'($urandom_range(0, 3));
         int          dd  = ($urandom_range(0, 15) == 0) ? 1000 : int'($urandom_range(0, 3));
         run(ent[11:6], f, id, dd, rb());
      end

      // Reset during the MEM wait of a lw
      build(6'h23, 6'h00, 0, 1000, 1'b0);
      play(3);
      plan.delete();
      op = 6'h23; func = '0; dmem_ack = 1'b0; imem_ack = 1'b0;
      #2;
      e = with_alu(3'd3, KLw);
      e.dreq = 1'b1;
      check("mem_before_rst", obs, e);
      reset_n = 1'b0;
      #1 check("mem_in_rst", obs, '0);
      @(posedge clk);
      #1 check("held_rst", obs, '0);
      reset_n = 1'b1;
      #1;
      e = '0;
      e.ireq = 1'b1;
      check("after_rst", obs, e);
      run(6'h00, 6'h23, 0, 0, 1'b0);     // subu completes cleanly after reset

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
